// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache that fetches each missed word from the memory controller.
// Optional hit/miss counters are included when ICACHE_STATS_EN is defined.
module icache_responder #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic        flush
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state, next_state;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS];
    logic [31:0]        faddr;
    logic               fl_pend;

    logic [IDX_W-1:0]   idx, fidx;
    logic [TAG_W-1:0]   tag, ftag;
    logic               lookup_hit;
    logic               miss;
    logic               fill_done;
    logic               unused_lsb;

    assign idx        = imemaddr[IDX_W+1:2];
    assign tag        = imemaddr[31:IDX_W+2];
    assign fidx       = faddr[IDX_W+1:2];
    assign ftag       = faddr[31:IDX_W+2];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
    assign unused_lsb = ^imemaddr[1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            faddr   <= '0;
            valid_q <= '0;
            fl_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (miss)
                faddr <= {imemaddr[31:2], 2'b00};
            // A flush seen at any point of a fill must keep that fill from allocating.
            if (flush)
                valid_q <= '0;
            else if (fill_done && !fl_pend)
                valid_q[fidx] <= 1'b1;
            if (fill_done)
                fl_pend <= 1'b0;
            else if (state == FILL && flush)
                fl_pend <= 1'b1;
        end
    end

    // Tag and data arrays are qualified by valid_q, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fidx]  <= ftag;
            data_q[fidx] <= iload;
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        miss       = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        ihit     = 1'b1;
                        imemload = data_q[idx];
                    end else begin
                        miss       = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = faddr;
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                    if (imemREN && (imemaddr[31:2] == faddr[31:2]) && !flush && !fl_pend) begin
                        ihit     = 1'b1;
                        imemload = iload;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef ICACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit)
                hit_count <= sat_inc(hit_count);
            if (miss)
                miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: fills, hits, eviction, mid-fill changes, flush and reset.
// Also checks the hit/miss counters when ICACHE_STATS_EN is defined.
module tb_icache_responder;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        flush;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    icache_responder dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
`ifdef ICACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .flush      (flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic cyc(input logic r, input logic ren, input logic [31:0] a,
                       input logic w, input logic [31:0] ld, input logic fl);
        @(posedge CLK);
        #1;
        RST      = r;
        imemREN  = ren;
        imemaddr = a;
        iwait    = w;
        iload    = ld;
        flush    = fl;
        @(negedge CLK);
    endtask

    task automatic do_fill(input logic [31:0] a, input logic [31:0] d, input int nw);
        cyc(0, 1, a, 1, 32'h0, 0);
        chk("miss_ihit", ihit, 0);
        chk("miss_iren", iREN, 0);
        for (int i = 0; i < nw; i++) begin
            cyc(0, 1, a, 1, 32'h0, 0);
            chk("wait_iren", iREN, 1);
            chk("wait_iaddr", iaddr, a);
            chk("wait_ihit", ihit, 0);
        end
        cyc(0, 1, a, 0, d, 0);
        chk("done_iren", iREN, 1);
        chk("done_iaddr", iaddr, a);
        chk("byp_ihit", ihit, 1);
        chk("byp_load", imemload, d);
    endtask

    task automatic expect_hit(input logic [31:0] a, input logic [31:0] d);
        cyc(0, 1, a, 1, 32'h0, 0);
        chk("hit_ihit", ihit, 1);
        chk("hit_load", imemload, d);
        chk("hit_iren", iREN, 0);
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0; flush = 1'b0;

        // Reset state
        cyc(1, 0, 32'h0, 1, 32'h0, 0);
        cyc(1, 1, 32'h40, 1, 32'h0, 0);
        chk("rst_ihit", ihit, 0);
        chk("rst_iren", iREN, 0);
        chk("rst_load", imemload, 0);
        chk("rst_iaddr", iaddr, 0);

        // Cold miss with three wait cycles, then an immediate hit
        do_fill(32'h40, 32'h2001_0005, 3);
        expect_hit(32'h40, 32'h2001_0005);
        cyc(0, 0, 32'h40, 1, 32'h0, 0);
        chk("noreq_ihit", ihit, 0);
        chk("noreq_load", imemload, 0);

        // Conflict eviction on index 0
        do_fill(32'h440, 32'hAAAA_0440, 1);
        expect_hit(32'h440, 32'hAAAA_0440);
        do_fill(32'h40, 32'h1111_0040, 0);
        expect_hit(32'h40, 32'h1111_0040);

        // Address change mid-fill
        cyc(0, 1, 32'h80, 1, 32'h0, 0);
        chk("chg_miss", ihit, 0);
        cyc(0, 1, 32'h84, 1, 32'h0, 0);
        chk("chg_iaddr", iaddr, 32'h80);
        cyc(0, 1, 32'h84, 0, 32'h0080_DA7A, 0);
        chk("chg_done_iren", iREN, 1);
        chk("chg_no_byp", ihit, 0);
        cyc(0, 1, 32'h84, 1, 32'h0, 0);
        chk("chg_new_miss", ihit, 0);
        chk("chg_new_iren", iREN, 0);
        cyc(0, 1, 32'h84, 0, 32'h0084_0084, 0);
        chk("chg_new_iaddr", iaddr, 32'h84);
        chk("chg_new_byp", imemload, 32'h0084_0084);
        expect_hit(32'h80, 32'h0080_DA7A);

        // Flush in IDLE: lookup in the flush cycle still hits, later access misses
        do_fill(32'h0, 32'h0000_00F0, 0);
        do_fill(32'h4, 32'h0000_00F4, 1);
        cyc(0, 1, 32'h0, 1, 32'h0, 1);
        chk("fl_same_cyc_hit", ihit, 1);
        do_fill(32'h0, 32'h0000_00F0, 0);
        do_fill(32'h4, 32'h0000_00F4, 0);

        // Flush during a fill of 0x8
        cyc(0, 1, 32'h8, 1, 32'h0, 0);
        cyc(0, 1, 32'h8, 1, 32'h0, 1);
        chk("flf_wait_iren", iREN, 1);
        cyc(0, 1, 32'h8, 0, 32'h0000_0088, 0);
        chk("flf_done_iren", iREN, 1);
        chk("flf_no_byp", ihit, 0);
        do_fill(32'h8, 32'h0000_0088, 0);

        // Flush on the completing edge
        cyc(0, 1, 32'hC, 1, 32'h0, 0);
        cyc(0, 1, 32'hC, 0, 32'h0000_008C, 1);
        chk("flc_no_byp", ihit, 0);
        do_fill(32'hC, 32'h0000_008C, 0);

        // Reset mid-fill
        do_fill(32'h10, 32'h0000_1010, 0);
        expect_hit(32'h10, 32'h0000_1010);
        cyc(0, 1, 32'h100, 1, 32'h0, 0);
        cyc(0, 1, 32'h100, 1, 32'h0, 0);
        chk("rmf_iren_before", iREN, 1);
        cyc(1, 0, 32'h100, 1, 32'h0, 0);
        cyc(0, 0, 32'h100, 1, 32'h0, 0);
        chk("rmf_iren", iREN, 0);
        chk("rmf_ihit", ihit, 0);
        chk("rmf_iaddr", iaddr, 0);
        do_fill(32'h10, 32'h0000_1010, 0);

`ifdef ICACHE_STATS_EN
        // Counters: two misses with bypass, then five hit cycles
        cyc(1, 0, 32'h0, 1, 32'h0, 0);
        cyc(0, 0, 32'h0, 1, 32'h0, 0);
        chk("st_rst_hit", hit_count, 0);
        chk("st_rst_miss", miss_count, 0);
        do_fill(32'h200, 32'h0000_0200, 1);
        do_fill(32'h204, 32'h0000_0204, 0);
        for (int i = 0; i < 5; i++)
            expect_hit((i % 2 == 0) ? 32'h200 : 32'h204, (i % 2 == 0) ? 32'h200 : 32'h204);
        cyc(0, 0, 32'h0, 1, 32'h0, 0);
        chk("st_miss_count", miss_count, 2);
        chk("st_hit_count", hit_count, 7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
